// File: rtl/alarm_seq_pkg.sv
// Purpose: shared constants, op/state enums and write-data helpers for the alarm APB sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_seq_pkg;

    localparam logic [31:0] ADDR_TIME      = 32'h0000_0000;
    localparam logic [31:0] ADDR_ALARM     = 32'h0000_0004;
    localparam logic [31:0] ADDR_READ_TIME = 32'h0000_0008;
    localparam logic [31:0] ADDR_ALARM_OFF = 32'h0000_000C;

    // Bit in the time register that strobes the written value into the clock.
    localparam int TIME_LOAD_BIT = 16;

    typedef enum logic [1:0] {
        OP_SET_TIME  = 2'd0,
        OP_SET_ALARM = 2'd1,
        OP_GET_TIME  = 2'd2,
        OP_ALARM_OFF = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        GAP    = 3'd3,
        RESP   = 3'd4
    } state_e;

    // APB address for a command.
    function automatic logic [31:0] op_addr(input op_e op);
        case (op)
            OP_SET_TIME:  return ADDR_TIME;
            OP_SET_ALARM: return ADDR_ALARM;
            OP_GET_TIME:  return ADDR_READ_TIME;
            default:      return ADDR_ALARM_OFF;
        endcase
    endfunction

    // Write data for a command; SET_TIME toggles the load bit high/low/high
    // across its three writes so the slave sees a clean load edge.
    function automatic logic [31:0] op_wdata(input op_e op, input logic [31:0] d,
                                             input logic [1:0] idx);
        logic [31:0] load_mask;
        load_mask = 32'h1 << TIME_LOAD_BIT;
        case (op)
            OP_SET_TIME:  return (idx == 2'd1) ? (d & ~load_mask) : (d | load_mask);
            OP_SET_ALARM: return d;
            OP_GET_TIME:  return 32'h0;
            default:      return 32'h1;
        endcase
    endfunction

endpackage

// File: rtl/alarm_apb_sequencer.sv
// Purpose: turns alarm/time commands into APB master transfers (SET_TIME = 3 spaced writes).
// Latency: single-access ops respond 3 cycles after accept with zero-wait slave; SET_TIME 7+2*GAP_CYCLES.
// Backpressure: one command in flight; cmd_ready only in IDLE, requests while busy are dropped; no rsp backpressure.
module alarm_apb_sequencer
    import alarm_seq_pkg::*;
#(
    parameter int GAP_CYCLES     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        pclk_i,
    input  logic        preset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    // Counter reload values: the counter counts down to zero inclusive,
    // so loading N-1 yields exactly N cycles.
    localparam logic [7:0] GAP_LOAD     = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES - 1);

    state_e      state, state_n;
    op_e         op_q, op_n;
    logic [31:0] data_q, data_n;
    logic [1:0]  idx_q, idx_n;
    logic [7:0]  cnt_q, cnt_n;       // shared gap / access-timeout down-counter
    logic [31:0] rsp_data_q, rsp_data_n;
    logic        rsp_err_q, rsp_err_n;

    logic in_xfer;
    logic is_write;
    logic last_write;

    // APB outputs are decoded from latched command state, so they are stable through SETUP and ACCESS.
    always_comb begin
        in_xfer     = (state == SETUP) || (state == ACCESS);
        is_write    = (op_q != OP_GET_TIME);
        last_write  = (op_q != OP_SET_TIME) || (idx_q == 2'd2);
        psel_o      = in_xfer;
        penable_o   = (state == ACCESS);
        paddr_o     = in_xfer ? op_addr(op_q) : 32'h0;
        pwrite_o    = in_xfer && is_write;
        pwdata_o    = in_xfer ? op_wdata(op_q, data_q, idx_q) : 32'h0;
        pstrb_o     = (in_xfer && is_write) ? 4'hF : 4'h0;
        cmd_ready_o = (state == IDLE) && !preset_i;
        rsp_valid_o = (state == RESP);
        rsp_data_o  = rsp_data_q;
        rsp_err_o   = rsp_err_q;
    end

    // Next-state, counter and response computation.
    always_comb begin
        state_n    = state;
        op_n       = op_q;
        data_n     = data_q;
        idx_n      = idx_q;
        cnt_n      = cnt_q;
        rsp_data_n = rsp_data_q;
        rsp_err_n  = rsp_err_q;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    op_n    = op_e'(cmd_op_i);
                    data_n  = cmd_data_i;
                    idx_n   = 2'd0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                cnt_n   = TIMEOUT_LOAD;
                state_n = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    if (pslverr_i || last_write) begin
                        // Response fields change only on entry to RESP so they hold between responses.
                        state_n    = RESP;
                        rsp_err_n  = pslverr_i;
                        rsp_data_n = is_write ? 32'h0 : prdata_i;
                    end else begin
                        state_n = GAP;
                        cnt_n   = GAP_LOAD;
                        idx_n   = idx_q + 2'd1;
                    end
                end else if (cnt_q == 8'd0) begin
                    state_n    = RESP;
                    rsp_err_n  = 1'b1;
                    rsp_data_n = 32'h0;
                end else begin
                    cnt_n = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_n = SETUP;
                end else begin
                    cnt_n = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer without a response.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state      <= IDLE;
            op_q       <= OP_SET_TIME;
            data_q     <= 32'h0;
            idx_q      <= 2'd0;
            cnt_q      <= 8'd0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            data_q     <= data_n;
            idx_q      <= idx_n;
            cnt_q      <= cnt_n;
            rsp_data_q <= rsp_data_n;
            rsp_err_q  <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_alarm_apb_sequencer.sv
// Purpose: directed self-checking bench for alarm_apb_sequencer with an inline APB slave.
// Latency: checks response cycle counts relative to the accept cycle.
// Backpressure: slave wait states, errors and timeouts are scripted per step.
module tb_alarm_apb_sequencer;

    logic        pclk_i;
    logic        preset_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    alarm_apb_sequencer #(.GAP_CYCLES(5), .TIMEOUT_CYCLES(16)) dut (
        .pclk_i(pclk_i), .preset_i(preset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    initial pclk_i = 1'b0;
    always #5 pclk_i = ~pclk_i;

    int asserts = 0;
    int fails   = 0;

    // Slave script.
    int          slv_wait;
    int          slv_err_at;
    bit          slv_never;
    logic [31:0] slv_rdata;
    bit          hold_valid;

    // Observations from the last command.
    int          nsetup, ncomp, rsp_cyc, acc_max, ready_busy, unstable;
    logic [31:0] wr_addr [4];
    logic [31:0] wr_data [4];
    logic [3:0]  wr_strb [4];
    logic        wr_write [4];
    int          gap_len [4];
    logic        r_err;
    logic [31:0] r_data;
    int          cnt_rsp, cnt_psel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command and act as APB slave until the response or max_cyc cycles.
    // Cycle k counts from the accept cycle (k=1 is the first cycle after acceptance).
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] d, input int max_cyc);
        int acc_run;
        int low_run;
        acc_run = 0; low_run = 0;
        nsetup = 0; ncomp = 0; rsp_cyc = -1; acc_max = 0; ready_busy = 0; unstable = 0;
        r_err = 1'bx; r_data = 32'hx;
        for (int i = 0; i < 4; i++) begin
            wr_addr[i] = 32'hx; wr_data[i] = 32'hx; wr_strb[i] = 4'hx; wr_write[i] = 1'bx;
            gap_len[i] = -1;
        end
        @(negedge pclk_i);
        chk("cmd_ready_before_accept", {31'b0, cmd_ready_o}, 32'd1);
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_data_i = d;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge pclk_i);
            if (!hold_valid) cmd_valid_i = 1'b0;
            pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'hDEAD_BEEF;
            if (cmd_ready_o) ready_busy++;
            if (psel_o && !penable_o) begin
                if (nsetup > 0 && nsetup < 4) gap_len[nsetup-1] = low_run;
                if (nsetup < 4) begin
                    wr_addr[nsetup] = paddr_o; wr_data[nsetup] = pwdata_o;
                    wr_strb[nsetup] = pstrb_o; wr_write[nsetup] = pwrite_o;
                end
                nsetup++; acc_run = 0; low_run = 0;
            end else if (psel_o && penable_o) begin
                acc_run++;
                if (acc_run > acc_max) acc_max = acc_run;
                if (nsetup >= 1 && nsetup <= 4) begin
                    if (paddr_o !== wr_addr[nsetup-1] || pwdata_o !== wr_data[nsetup-1] ||
                        pstrb_o !== wr_strb[nsetup-1] || pwrite_o !== wr_write[nsetup-1])
                        unstable++;
                end
                if (!slv_never && acc_run > slv_wait) begin
                    pready_i  = 1'b1;
                    pslverr_i = (ncomp == slv_err_at);
                    prdata_i  = slv_rdata;
                    ncomp++;
                end
            end else begin
                low_run++;
            end
            if (rsp_valid_o) begin
                rsp_cyc = k; r_err = rsp_err_o; r_data = rsp_data_o;
                cmd_valid_i = 1'b0;
                break;
            end
        end
        cmd_valid_i = 1'b0;
        @(negedge pclk_i);
        chk("rsp_valid_single_cycle", {31'b0, rsp_valid_o}, 32'd0);
        chk("cmd_ready_after_resp", {31'b0, cmd_ready_o}, 32'd1);
    endtask

    initial begin
        preset_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_data_i = 32'h0;
        prdata_i = 32'h0; pready_i = 1'b0; pslverr_i = 1'b0;
        slv_wait = 0; slv_err_at = -1; slv_never = 1'b0; slv_rdata = 32'h0; hold_valid = 1'b0;

        // Reset state.
        repeat (3) @(negedge pclk_i);
        chk("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
        chk("rst_psel", {31'b0, psel_o}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_pstrb", {28'b0, pstrb_o}, 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        preset_i = 1'b0;
        @(negedge pclk_i);
        chk("rel_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        chk("rel_rsp_err", {31'b0, rsp_err_o}, 32'd0);

        // SET_ALARM 0x11100, zero-wait slave.
        run_cmd(2'd1, 32'h0001_1100, 30);
        chk("alarm_nsetup", nsetup, 32'd1);
        chk("alarm_addr", wr_addr[0], 32'h4);
        chk("alarm_wdata", wr_data[0], 32'h0001_1100);
        chk("alarm_strb", {28'b0, wr_strb[0]}, 32'hF);
        chk("alarm_pwrite", {31'b0, wr_write[0]}, 32'd1);
        chk("alarm_rsp_cyc", rsp_cyc, 32'd3);
        chk("alarm_err", {31'b0, r_err}, 32'd0);
        chk("alarm_data", r_data, 32'd0);
        chk("alarm_stable", unstable, 32'd0);

        // SET_TIME 0x11052: three writes with 5 idle cycles between them.
        run_cmd(2'd0, 32'h0001_1052, 40);
        chk("time_nsetup", nsetup, 32'd3);
        chk("time_addr0", wr_addr[0], 32'h0);
        chk("time_addr2", wr_addr[2], 32'h0);
        chk("time_wdata0", wr_data[0], 32'h0001_1052);
        chk("time_wdata1", wr_data[1], 32'h0000_1052);
        chk("time_wdata2", wr_data[2], 32'h0001_1052);
        chk("time_strb1", {28'b0, wr_strb[1]}, 32'hF);
        chk("time_gap0", gap_len[0], 32'd5);
        chk("time_gap1", gap_len[1], 32'd5);
        chk("time_rsp_cyc", rsp_cyc, 32'd17);
        chk("time_err", {31'b0, r_err}, 32'd0);
        chk("time_stable", unstable, 32'd0);

        // GET_TIME with 2 wait states.
        slv_wait = 2; slv_rdata = 32'h0001_1053;
        run_cmd(2'd2, 32'hFFFF_FFFF, 30);
        chk("get_addr", wr_addr[0], 32'h8);
        chk("get_pwrite", {31'b0, wr_write[0]}, 32'd0);
        chk("get_strb", {28'b0, wr_strb[0]}, 32'd0);
        chk("get_wdata", wr_data[0], 32'd0);
        chk("get_rsp_cyc", rsp_cyc, 32'd5);
        chk("get_data", r_data, 32'h0001_1053);
        chk("get_err", {31'b0, r_err}, 32'd0);
        chk("get_data_hold", rsp_data_o, 32'h0001_1053);
        chk("get_stable", unstable, 32'd0);

        // SET_TIME with slave error on the second write.
        slv_wait = 0; slv_err_at = 1;
        run_cmd(2'd0, 32'h0000_0001, 40);
        chk("serr_nsetup", nsetup, 32'd2);
        chk("serr_rsp_cyc", rsp_cyc, 32'd10);
        chk("serr_err", {31'b0, r_err}, 32'd1);
        chk("serr_data", r_data, 32'd0);
        slv_err_at = -1;

        // ALARM_OFF with pready never asserted: timeout after 16 access cycles.
        slv_never = 1'b1;
        run_cmd(2'd3, 32'h1234_5678, 40);
        chk("tmo_addr", wr_addr[0], 32'hC);
        chk("tmo_wdata", wr_data[0], 32'h1);
        chk("tmo_access_cycles", acc_max, 32'd16);
        chk("tmo_rsp_cyc", rsp_cyc, 32'd18);
        chk("tmo_err", {31'b0, r_err}, 32'd1);
        slv_never = 1'b0;

        // cmd_valid held high while busy is neither accepted nor queued.
        hold_valid = 1'b1;
        run_cmd(2'd1, 32'h0000_00AA, 30);
        chk("hold_nsetup", nsetup, 32'd1);
        chk("hold_rsp_cyc", rsp_cyc, 32'd3);
        chk("hold_ready_busy", ready_busy, 32'd0);
        chk("hold_err_cleared", {31'b0, r_err}, 32'd0);
        hold_valid = 1'b0;
        cnt_psel = 0;
        repeat (4) begin
            @(negedge pclk_i);
            if (psel_o) cnt_psel++;
        end
        chk("hold_no_queued", cnt_psel, 32'd0);

        // Reset in the middle of a SET_TIME access phase.
        slv_never = 1'b1;
        @(negedge pclk_i);
        cmd_valid_i = 1'b1; cmd_op_i = 2'd0; cmd_data_i = 32'h0001_1052;
        @(negedge pclk_i);
        cmd_valid_i = 1'b0;
        chk("mrst_setup", {30'b0, psel_o, penable_o}, 32'b10);
        @(negedge pclk_i);
        chk("mrst_access", {30'b0, psel_o, penable_o}, 32'b11);
        chk("mrst_access_wdata", pwdata_o, 32'h0001_1052);
        preset_i = 1'b1;
        @(negedge pclk_i);
        chk("mrst_psel_dropped", {30'b0, psel_o, penable_o}, 32'b00);
        chk("mrst_ready_in_reset", {31'b0, cmd_ready_o}, 32'd0);
        chk("mrst_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        preset_i = 1'b0;
        @(negedge pclk_i);
        chk("mrst_ready_after", {31'b0, cmd_ready_o}, 32'd1);
        cnt_rsp = 0; cnt_psel = 0;
        repeat (20) begin
            @(negedge pclk_i);
            if (rsp_valid_o) cnt_rsp++;
            if (psel_o) cnt_psel++;
        end
        chk("mrst_no_rsp_later", cnt_rsp, 32'd0);
        chk("mrst_no_psel_later", cnt_psel, 32'd0);
        slv_never = 1'b0;

        // Normal operation resumes after the abort.
        run_cmd(2'd1, 32'h0000_0707, 30);
        chk("post_rsp_cyc", rsp_cyc, 32'd3);
        chk("post_wdata", wr_data[0], 32'h0000_0707);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/alarm_apb_sequencer.md
ALARM_APB_SEQUENCER -- requirements
Module: alarm_apb_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 5: idle cycles (psel_o low) between the writes of a time-set sequence; legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum access-phase cycles waiting for pready_i; legal range 1..255.
REQ-003 SHALL use one clock, pclk_i (in, 1); all logic rises on its edge.
REQ-004 SHALL use preset_i (in, 1): synchronous, active-high reset.
REQ-005 SHALL have cmd_valid_i (in, 1): command request.
REQ-006 SHALL have cmd_ready_o (out, 1): sequencer accepts a command.
REQ-007 SHALL have cmd_op_i (in, 2): 0 SET_TIME, 1 SET_ALARM, 2 GET_TIME, 3 ALARM_OFF.
REQ-008 SHALL have cmd_data_i (in, 32): command payload.
REQ-009 SHALL have rsp_valid_o (out, 1): one-cycle completion pulse.
REQ-010 SHALL have rsp_data_o (out, 32) and rsp_err_o (out, 1): read data and error flag.
REQ-011 SHALL have APB master outputs paddr_o (32), psel_o (1), penable_o (1), pwrite_o (1), pwdata_o (32), pstrb_o (4).
REQ-012 SHALL have APB master inputs prdata_i (32), pready_i (1), pslverr_i (1).

Function
REQ-013 SHALL set cmd_ready_o high only in IDLE; a command is accepted on cmd_valid_i && cmd_ready_o, and op and data are latched.
REQ-014 SHALL use FSM states IDLE, SETUP, ACCESS, GAP and RESP. Transitions: IDLE->SETUP on accept; SETUP->ACCESS after 1 cycle; ACCESS->GAP or RESP on pready_i; GAP->SETUP after GAP_CYCLES; RESP->IDLE after 1 cycle.
REQ-015 SETUP SHALL drive psel_o=1 and penable_o=0. ACCESS SHALL drive psel_o=1 and penable_o=1. All other states SHALL drive psel_o=0 and penable_o=0.
REQ-016 paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL remain stable from SETUP through the end of ACCESS.
REQ-017 Writes SHALL use pstrb_o=4'b1111; reads SHALL use pstrb_o=0 and pwdata_o=0.
REQ-018 SET_TIME SHALL perform 3 writes to 0x0 with data D|bit16, then D&~bit16, then D|bit16, with GAP between writes.
REQ-019 SET_ALARM SHALL perform 1 write of D to 0x4.
REQ-020 GET_TIME SHALL perform 1 read of 0x8; rsp_data_o = prdata_i sampled at the pready_i cycle.
REQ-021 ALARM_OFF SHALL perform 1 write of 32'h1 to 0xC.
REQ-022 rsp_data_o SHALL be 0 for write commands and SHALL hold its value until the next RESP.
REQ-023 pslverr_i=1 at a pready_i cycle SHALL set rsp_err_o=1, skip any remaining writes of the sequence and go straight to RESP.
REQ-024 If pready_i is absent for TIMEOUT_CYCLES access cycles, the sequencer SHALL drop psel_o/penable_o, set rsp_err_o=1 and go to RESP.
REQ-025 rsp_valid_o SHALL be high exactly in RESP, with no backpressure; rsp_err_o SHALL be valid with it.
REQ-026 Latency for SET_ALARM/GET_TIME/ALARM_OFF with zero-wait pready_i: accept at T, SETUP T+1, ACCESS T+2, rsp_valid_o T+3.
REQ-027 Latency for SET_TIME with zero-wait pready_i: rsp_valid_o at T+7+2*GAP_CYCLES.
REQ-028 cmd_valid_i outside IDLE SHALL be ignored (not queued).

Reset
REQ-029 preset_i=1 at an edge SHALL force IDLE, clear the gap and timeout counters, and set all outputs to 0 except cmd_ready_o, which is 0 during reset and 1 from the first cycle after release.
REQ-030 Reset during any phase SHALL abort the transfer without a response; psel_o=0 at the next edge.

Structure
REQ-031 Package alarm_seq_pkg SHALL hold the address constants (0x0, 0x4, 0x8, 0xC), TIME_LOAD_BIT=16, the op enum and the state enum.
REQ-032 The design SHALL be a single module with no sub-module; gap and timeout SHALL share one 8-bit down-counter.

Verification
REQ-033 SET_ALARM 32'h11100 with zero-wait slave: one write to 0x4 with pwdata 32'h11100 and pstrb 4'hF -> rsp_valid_o at T+3, rsp_err_o=0.
REQ-034 SET_TIME 32'h11052 with GAP_CYCLES=5: writes 0x11052, 0x01052, 0x11052 to 0x0, exactly 5 psel-low cycles between writes -> rsp_valid_o at T+17.
REQ-035 GET_TIME with slave returning 32'h00011053 after 2 wait states -> rsp_data_o=32'h00011053 at T+5, error 0.
REQ-036 SET_TIME with pslverr_i=1 on the 2nd write -> only 2 writes are issued, rsp_err_o=1.
REQ-037 ALARM_OFF with pready_i held low -> psel_o drops after 16 access cycles, rsp_err_o=1.
REQ-038 preset_i asserted mid-ACCESS of SET_TIME -> psel_o=0 at the next edge, no rsp_valid_o, and cmd_ready_o=1 after release.
